// File: rtl/npc_pkg.sv
// Shared definitions for the npc core: RV32 major opcodes, controller
// states and the opcode class record produced by the classifier.
package npc_pkg;

   localparam int unsigned OPC_W = 7;

   localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_OPIMM  = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   typedef struct packed {
      logic legal;
      logic is_mem;
      logic is_store;
      logic writes_rd;
      logic is_sys;
   } opclass_t;

endpackage

// File: rtl/npc_ctrl_if.sv
// Handshake bundle between the sequencing controller and the fetch, LSU,
// decoder and writeback logic of the core.
interface npc_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic                      ifu_req;
   logic                      ifu_rvalid;
   logic                      inst_we;
   logic [npc_pkg::OPC_W-1:0] opcode;
   logic                      ebreak;
   logic                      lsu_req;
   logic                      lsu_wen;
   logic                      lsu_ack;
   logic                      rf_we;
   logic                      pc_we;
   logic                      halt;
   logic                      bad_inst;
   logic                      timeout;
   logic [CNT_W-1:0]          retired;

   modport master (
      input  ifu_rvalid, opcode, ebreak, lsu_ack,
      output ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we,
             halt, bad_inst, timeout, retired
   );

   modport slave (
      output ifu_rvalid, opcode, ebreak, lsu_ack,
      input  ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we,
             halt, bad_inst, timeout, retired
   );
endinterface

// File: rtl/npc_opclass.sv
// Combinational RV32 major-opcode classifier: legality, memory access,
// store, destination-register write and SYSTEM flags.
module npc_opclass
   import npc_pkg::*;
(
   input  logic [OPC_W-1:0] i_opcode,
   output opclass_t         o_class
);

   always_comb begin
      o_class = '0;
      case (i_opcode)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM: begin
            o_class.legal     = 1'b1;
            o_class.writes_rd = 1'b1;
         end
         OP_LOAD: begin
            o_class.legal     = 1'b1;
            o_class.is_mem    = 1'b1;
            o_class.writes_rd = 1'b1;
         end
         OP_STORE: begin
            o_class.legal    = 1'b1;
            o_class.is_mem   = 1'b1;
            o_class.is_store = 1'b1;
         end
         OP_BRANCH: o_class.legal = 1'b1;
         OP_SYSTEM: begin
            o_class.legal  = 1'b1;
            o_class.is_sys = 1'b1;
         end
         default: o_class = '0;
      endcase
   end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32 core, with
// ebreak/illegal-opcode halt, memory-wait timeout and retired counter.
module npc_ctrl
   import npc_pkg::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned TO_W  = 8
)(
   input  logic       clk,
   input  logic       rst,
   npc_ctrl_if.master bus
);

   state_t           r_state;
   state_t           w_next;
   opclass_t         w_class;
   logic             r_is_mem;
   logic             r_is_store;
   logic             r_writes_rd;
   logic [TO_W-1:0]  r_to;
   logic [CNT_W-1:0] r_retired;
   logic             r_ifu_req;
   logic             r_lsu_req;
   logic             r_lsu_wen;
   logic             r_rf_we;
   logic             r_pc_we;
   logic             r_halt;
   logic             r_bad;
   logic             r_timeout;
   logic             w_fetch_done;
   logic             w_mem_done;
   logic             w_to_sat;
   logic             w_waiting;

   npc_opclass u_opclass (
      .i_opcode (bus.opcode),
      .o_class  (w_class)
   );

   // r_to holds the 1-based index of the current waiting cycle, so all-ones
   // marks the last cycle in which a response is still accepted.
   assign w_to_sat     = (r_to == '1);
   assign w_waiting    = r_ifu_req || r_lsu_req;
   assign w_fetch_done = r_ifu_req && bus.ifu_rvalid;
   assign w_mem_done   = r_lsu_req && bus.lsu_ack;

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH: begin
            if (w_fetch_done)                w_next = DECODE;
            else if (r_ifu_req && w_to_sat)  w_next = HALT;
         end
         DECODE: begin
            if (!w_class.legal || (w_class.is_sys && bus.ebreak)) w_next = HALT;
            else                                                  w_next = EXEC;
         end
         EXEC:    w_next = r_is_mem ? MEM : WB;
         MEM: begin
            if (w_mem_done)     w_next = WB;
            else if (w_to_sat)  w_next = HALT;
         end
         WB:      w_next = FETCH;
         HALT:    w_next = HALT;
         default: w_next = FETCH;
      endcase
   end

   // Outputs are registered from the state being entered, so each is valid
   // for exactly the cycles spent in its state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= FETCH;
         r_is_mem    <= 1'b0;
         r_is_store  <= 1'b0;
         r_writes_rd <= 1'b0;
         r_to        <= TO_W'(1);
         r_retired   <= '0;
         r_ifu_req   <= 1'b0;
         r_lsu_req   <= 1'b0;
         r_lsu_wen   <= 1'b0;
         r_rf_we     <= 1'b0;
         r_pc_we     <= 1'b0;
         r_halt      <= 1'b0;
         r_bad       <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_ifu_req <= (w_next == FETCH);
         r_lsu_req <= (w_next == MEM);
         r_lsu_wen <= (w_next == MEM) && r_is_store;
         r_rf_we   <= (w_next == WB) && r_writes_rd;
         r_pc_we   <= (w_next == WB);
         r_halt    <= (w_next == HALT);

         if (r_state == DECODE) begin
            r_is_mem    <= w_class.is_mem;
            r_is_store  <= w_class.is_store;
            r_writes_rd <= w_class.writes_rd;
            if (!w_class.legal) r_bad <= 1'b1;
         end

         if (((r_state == FETCH) || (r_state == MEM)) && (w_next == HALT))
            r_timeout <= 1'b1;

         if (w_next != r_state)         r_to <= TO_W'(1);
         else if (w_waiting && !w_to_sat) r_to <= r_to + TO_W'(1);

         if (w_next == WB) r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign bus.ifu_req  = r_ifu_req;
   assign bus.inst_we  = w_fetch_done;
   assign bus.lsu_req  = r_lsu_req;
   assign bus.lsu_wen  = r_lsu_wen;
   assign bus.rf_we    = r_rf_we;
   assign bus.pc_we    = r_pc_we;
   assign bus.halt     = r_halt;
   assign bus.bad_inst = r_bad;
   assign bus.timeout  = r_timeout;
   assign bus.retired  = r_retired;

endmodule

// File: tb/tb_npc_ctrl.sv
// Bench for npc_ctrl: directed instruction table, hand-written halt/timeout/
// reset sequences and a randomized run checked against a transaction model.
module tb_npc_ctrl;

   localparam int unsigned CW       = 4;
   localparam int unsigned TW       = 4;
   localparam int          WAIT_MAX = (1 << TW) - 1;

   typedef struct {
      string      name;
      logic [6:0] op;
      logic       eb;
      int         fdly;
      int         adly;
      logic       wr;
      logic       mem;
      logic       st;
      int         kind;   // 0 retires, 1 illegal halt, 2 ebreak halt
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   npc_ctrl_if #(.CNT_W(CW)) bus ();

   npc_ctrl #(.CNT_W(CW), .TO_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   m_ret = 0;
   logic m_halt = 1'b0;
   logic m_bad  = 1'b0;
   logic m_to   = 1'b0;

   function automatic logic [6:0] rnd_op();
      return 7'($urandom_range(0, 127));
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic vec_t mk(string n, logic [6:0] op, logic eb, int fd, int ad,
                               logic wr, logic mem, logic st, int kind);
      vec_t v;
      v.name = n; v.op = op; v.eb = eb; v.fdly = fd; v.adly = ad;
      v.wr = wr; v.mem = mem; v.st = st; v.kind = kind;
      return v;
   endfunction

   // Reference classification straight from the ISA opcode map.
   function automatic void ref_class(input logic [6:0] op, input logic eb,
                                     output logic wr, output logic mem,
                                     output logic st, output int kind);
      mem = op inside {7'b0000011, 7'b0100011};
      st  = (op == 7'b0100011);
      wr  = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                       7'b0110011, 7'b0010011, 7'b0000011};
      if (!(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                       7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011}))
         kind = 1;
      else if (op == 7'b1110011 && eb)
         kind = 2;
      else
         kind = 0;
   endfunction

   task automatic drive(input logic rv, input logic ack, input logic [6:0] op, input logic eb);
      @(posedge clk);
      #2;
      bus.ifu_rvalid = rv;
      bus.lsu_ack    = ack;
      bus.opcode     = op;
      bus.ebreak     = eb;
      #1;
   endtask

   task automatic expect_out(input string name, input logic ifu, input logic iwe,
                             input logic lreq, input logic lwen, input logic rf, input logic pc);
      logic [CW+8:0] act;
      logic [CW+8:0] exp;
      act = {bus.ifu_req, bus.inst_we, bus.lsu_req, bus.lsu_wen, bus.rf_we, bus.pc_we,
             bus.halt, bus.bad_inst, bus.timeout, bus.retired};
      exp = {ifu, iwe, lreq, lwen, rf, pc, m_halt, m_bad, m_to, CW'(m_ret)};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: req,iwe,lreq,lwen,rf,pc,halt,bad,to = %b retired=%0d, required %b retired=%0d",
                  name, $time, act[CW+8:CW], act[CW-1:0], exp[CW+8:CW], exp[CW-1:0]);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst    = 1'b1;
      m_ret  = 0;
      m_halt = 1'b0;
      m_bad  = 1'b0;
      m_to   = 1'b0;
      #1;
      expect_out("reset_async", 0, 0, 0, 0, 0, 0);
      repeat (2) begin
         drive(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit());
         expect_out("reset_hold", 0, 0, 0, 0, 0, 0);
      end
      @(posedge clk);
      #2;
      rst            = 1'b0;
      bus.ifu_rvalid = 1'b0;
      bus.lsu_ack    = 1'b0;
      #1;
      expect_out("reset_release", 0, 0, 0, 0, 0, 0);
   endtask

   task automatic hold_halt(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         drive(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit());
         expect_out(name, 0, 0, 0, 0, 0, 0);
      end
   endtask

   // One instruction from its first FETCH cycle to WB or HALT, with the
   // expected outputs derived from the phase timeline.
   task automatic run_instr(input logic [6:0] op, input logic eb, input int fdly, input int adly,
                            input logic wr, input logic mem, input logic st, input int kind,
                            output logic halted);
      halted = 1'b0;
      for (int i = 0; i < fdly && i < WAIT_MAX; i++) begin
         drive(1'b0, rnd_bit(), rnd_op(), rnd_bit());
         expect_out("fetch_wait", 1, 0, 0, 0, 0, 0);
      end
      if (fdly >= WAIT_MAX) begin
         drive(1'b1, rnd_bit(), rnd_op(), rnd_bit());
         m_halt = 1'b1; m_to = 1'b1;
         expect_out("fetch_timeout", 0, 0, 0, 0, 0, 0);
         halted = 1'b1;
         return;
      end
      drive(1'b1, rnd_bit(), rnd_op(), rnd_bit());
      expect_out("fetch_resp", 1, 1, 0, 0, 0, 0);
      drive(rnd_bit(), rnd_bit(), op, eb);
      expect_out("decode", 0, 0, 0, 0, 0, 0);
      if (kind != 0) begin
         drive(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit());
         m_halt = 1'b1;
         if (kind == 1) m_bad = 1'b1;
         expect_out(kind == 1 ? "illegal_halt" : "ebreak_halt", 0, 0, 0, 0, 0, 0);
         halted = 1'b1;
         return;
      end
      drive(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit());
      expect_out("exec", 0, 0, 0, 0, 0, 0);
      if (mem) begin
         for (int i = 0; i < adly && i < WAIT_MAX; i++) begin
            drive(rnd_bit(), 1'b0, rnd_op(), rnd_bit());
            expect_out("mem_wait", 0, 0, 1, st, 0, 0);
         end
         if (adly >= WAIT_MAX) begin
            drive(rnd_bit(), 1'b1, rnd_op(), rnd_bit());
            m_halt = 1'b1; m_to = 1'b1;
            expect_out("mem_timeout", 0, 0, 0, 0, 0, 0);
            halted = 1'b1;
            return;
         end
         drive(rnd_bit(), 1'b1, rnd_op(), rnd_bit());
         expect_out("mem_ack", 0, 0, 1, st, 0, 0);
      end
      drive(rnd_bit(), rnd_bit(), rnd_op(), rnd_bit());
      m_ret = (m_ret + 1) % (1 << CW);
      expect_out("wb", 0, 0, 0, 0, wr, 1);
   endtask

   initial begin
      vec_t       tv [12];
      logic [6:0] legal_ops [10];
      logic       h;
      logic [6:0] op;
      logic       eb;
      logic       wr;
      logic       mem;
      logic       st;
      int         kind;
      int         fd;
      int         ad;

      bus.ifu_rvalid = 1'b0;
      bus.lsu_ack    = 1'b0;
      bus.opcode     = '0;
      bus.ebreak     = 1'b0;

      legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

      tv[0]  = mk("addi",    7'b0010011, 1'b0, 4,  0,  1'b1, 1'b0, 1'b0, 0);
      tv[1]  = mk("sw",      7'b0100011, 1'b0, 0,  3,  1'b0, 1'b1, 1'b1, 0);
      tv[2]  = mk("beq",     7'b1100011, 1'b0, 1,  0,  1'b0, 1'b0, 1'b0, 0);
      tv[3]  = mk("lui",     7'b0110111, 1'b0, 0,  0,  1'b1, 1'b0, 1'b0, 0);
      tv[4]  = mk("auipc",   7'b0010111, 1'b0, 2,  0,  1'b1, 1'b0, 1'b0, 0);
      tv[5]  = mk("jal",     7'b1101111, 1'b0, 0,  0,  1'b1, 1'b0, 1'b0, 0);
      tv[6]  = mk("jalr",    7'b1100111, 1'b0, 3,  0,  1'b1, 1'b0, 1'b0, 0);
      tv[7]  = mk("lw",      7'b0000011, 1'b0, 0,  0,  1'b1, 1'b1, 1'b0, 0);
      tv[8]  = mk("add_f14", 7'b0110011, 1'b0, 14, 0,  1'b1, 1'b0, 1'b0, 0);
      tv[9]  = mk("ecall",   7'b1110011, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0, 0);
      tv[10] = mk("lw_a14",  7'b0000011, 1'b0, 1,  14, 1'b1, 1'b1, 1'b0, 0);
      tv[11] = mk("illegal", 7'b1111111, 1'b0, 0,  0,  1'b0, 1'b0, 1'b0, 1);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         run_instr(tv[i].op, tv[i].eb, tv[i].fdly, tv[i].adly,
                   tv[i].wr, tv[i].mem, tv[i].st, tv[i].kind, h);
         if (h) hold_halt({tv[i].name, "_hold"}, 20);
      end

      do_reset();
      run_instr(7'b0010011, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, h);
      run_instr(7'b1110011, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0, 2, h);
      hold_halt("ebreak_hold", 100);

      do_reset();
      run_instr(7'b0010011, 1'b0, WAIT_MAX, 0, 1'b1, 1'b0, 1'b0, 0, h);
      hold_halt("fetch_to_hold", 5);

      do_reset();
      run_instr(7'b0010011, 1'b0, WAIT_MAX - 1, 0, 1'b1, 1'b0, 1'b0, 0, h);
      run_instr(7'b0010011, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, h);

      do_reset();
      run_instr(7'b0000011, 1'b0, 0, WAIT_MAX, 1'b1, 1'b1, 1'b0, 0, h);
      hold_halt("mem_to_hold", 5);

      // Reset lands in the second MEM cycle of a store.
      do_reset();
      run_instr(7'b0010011, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, h);
      drive(1'b1, 1'b0, rnd_op(), 1'b0);
      expect_out("mr_fetch", 1, 1, 0, 0, 0, 0);
      drive(1'b0, 1'b0, 7'b0100011, 1'b0);
      expect_out("mr_decode", 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b0, rnd_op(), 1'b0);
      expect_out("mr_exec", 0, 0, 0, 0, 0, 0);
      drive(1'b0, 1'b0, rnd_op(), 1'b0);
      expect_out("mr_mem", 0, 0, 1, 1, 0, 0);
      do_reset();
      run_instr(7'b0010011, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 0, h);

      do_reset();
      for (int i = 0; i < 18; i++)
         run_instr(7'b0010011, 1'b0, $urandom_range(0, 3), 0, 1'b1, 1'b0, 1'b0, 0, h);

      do_reset();
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 9)];
         else                          op = rnd_op();
         eb = (op == 7'b1110011) ? ($urandom_range(0, 3) == 0) : 1'b0;
         fd = ($urandom_range(0, 19) == 0) ? WAIT_MAX : int'($urandom_range(0, 6));
         ad = ($urandom_range(0, 19) == 0) ? WAIT_MAX : int'($urandom_range(0, 6));
         ref_class(op, eb, wr, mem, st, kind);
         run_instr(op, eb, fd, ad, wr, mem, st, kind, h);
         if (h) begin
            hold_halt("rand_halt", 3);
            do_reset();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
